// File: rtl/win_banner_square_pkg.sv
// win_banner_square_pkg: shared banner geometry, screen size and FSM state encoding.
package win_banner_square_pkg;
    localparam int BANNER_W = 128;
    localparam int BANNER_H = 64;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam logic signed [11:0] INIT_TOP_Y = -12'sd64;
    typedef enum logic [1:0] {ST_IDLE, ST_SLIDE, ST_HOLD, ST_DONE} state_t;
endpackage

// File: rtl/win_banner_square_frame_tick_counter.sv
// frame_tick_counter: counts frame pulses, synchronous clear has priority over counting.
module frame_tick_counter
    import win_banner_square_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_tick,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk) begin
        if (reset || i_clear) r_count <= '0;
        else if (i_tick) r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/win_banner_square.sv
// win_banner_square: "you win" banner that slides down, holds (optionally blinking), then stays shown.
// Optional blinking in HOLD is enabled by defining WIN_BANNER_BLINK_EN.
module win_banner_square
    import win_banner_square_pkg::*;
#(
    parameter int TOP_LEFT_X   = 256,
    parameter int TARGET_Y     = 208,
    parameter int SPEED        = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        gameWon,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        bannerActive
);
    localparam int CNT_W = $clog2((HOLD_FRAMES > BLINK_FRAMES ? HOLD_FRAMES : BLINK_FRAMES) + 1);
    localparam logic signed [11:0] TGT_Y = 12'(TARGET_Y);
    state_t             r_state;
    logic signed [11:0] r_top_y;
    logic [10:0]        r_off_x;
    logic [10:0]        r_off_y;
    logic               r_inside;
    logic [CNT_W-1:0]   w_hold_cnt;
    logic signed [11:0] w_step_y;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic               w_phase;
    logic               w_show;
    frame_tick_counter #(.W(CNT_W)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state != ST_HOLD),
        .i_tick  (startOfFrame),
        .o_count (w_hold_cnt)
    );
`ifdef WIN_BANNER_BLINK_EN
    logic [CNT_W-1:0] w_blink_cnt;
    logic             w_blink_wrap;
    logic             r_phase;
    assign w_blink_wrap = startOfFrame && (w_blink_cnt == CNT_W'(BLINK_FRAMES - 1));
    frame_tick_counter #(.W(CNT_W)) u_blink (
        .clk     (clk),
        .reset   (reset),
        .i_clear ((r_state != ST_HOLD) || w_blink_wrap),
        .i_tick  (startOfFrame),
        .o_count (w_blink_cnt)
    );
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_HOLD) r_phase <= 1'b1;
        else if (w_blink_wrap) r_phase <= ~r_phase;
    end
    assign w_phase = r_phase;
`else
    assign w_phase = 1'b1;
`endif
    always_comb begin
        w_step_y = r_top_y + 12'(SPEED);
        w_dx     = $signed({1'b0, pixelX}) - 12'(TOP_LEFT_X);
        w_dy     = $signed({1'b0, pixelY}) - r_top_y;
        w_show   = (r_state == ST_SLIDE) || (r_state == ST_DONE) || (r_state == ST_HOLD && w_phase);
        w_show   = w_show && w_dx >= 0 && w_dx < 12'(BANNER_W) && w_dy >= 0 && w_dy < 12'(BANNER_H);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_top_y  <= INIT_TOP_Y;
            r_inside <= 1'b0;
            r_off_x  <= '0;
            r_off_y  <= '0;
        end else begin
            r_inside <= w_show;
            r_off_x  <= w_show ? w_dx[10:0] : '0;
            r_off_y  <= w_show ? w_dy[10:0] : '0;
            if (r_state != ST_IDLE && !gameWon) begin
                r_state <= ST_IDLE;
                r_top_y <= INIT_TOP_Y;
            end else begin
                unique case (r_state)
                    ST_IDLE: if (gameWon) begin
                        r_state <= ST_SLIDE;
                        r_top_y <= INIT_TOP_Y;
                    end
                    ST_SLIDE: if (r_top_y == TGT_Y) r_state <= ST_HOLD;
                        else if (startOfFrame) r_top_y <= (w_step_y >= TGT_Y) ? TGT_Y : w_step_y;
                    ST_HOLD: if (w_hold_cnt == CNT_W'(HOLD_FRAMES)) r_state <= ST_DONE;
                    ST_DONE: r_top_y <= TGT_Y;
                endcase
            end
        end
    end
    assign offsetX         = r_off_x;
    assign offsetY         = r_off_y;
    assign InsideRectangle = r_inside;
    assign bannerActive    = r_state != ST_IDLE;
endmodule

// File: tb/tb_win_banner_square.sv
// tb_win_banner_square: directed checks of slide, scan, hold/blink, drop and reset behaviour.
module tb_win_banner_square;
    import win_banner_square_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        gameWon = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        bannerActive;
    int n_checks = 0;
    int n_fail = 0;
`ifdef WIN_BANNER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    always #5 clk = ~clk;
    win_banner_square dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameWon(gameWon),
        .pixelX(pixelX), .pixelY(pixelY), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .bannerActive(bannerActive)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask
    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gameWon = 1'b1;
        tick();
    endtask
    task automatic test_reset();
        reset = 1'b1; gameWon = 1'b1; pixelX = 11'd300; pixelY = 11'd10;
        tick(); tick();
        n_checks++; if ({InsideRectangle, bannerActive, offsetX, offsetY} !== 24'd0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", {InsideRectangle, bannerActive, offsetX, offsetY}); end
        n_checks++; if (dut.r_top_y !== -12'sd64) begin n_fail++; $display("FAIL reset_topy got %0d exp -64", $signed(dut.r_top_y)); end
        reset = 1'b0; gameWon = 1'b0;
        tick();
        n_checks++; if (bannerActive !== 1'b0) begin n_fail++; $display("FAIL idle_no_won got %b exp 0", bannerActive); end
    endtask
    task automatic test_slide();
        logic signed [11:0] ey;
        restart();
        n_checks++; if (bannerActive !== 1'b1) begin n_fail++; $display("FAIL slide_active got %b exp 1", bannerActive); end
        n_checks++; if (dut.r_top_y !== -12'sd64) begin n_fail++; $display("FAIL slide_start got %0d exp -64", $signed(dut.r_top_y)); end
        ey = -12'sd64;
        for (int p = 1; p <= 68; p++) begin
            frame();
            ey = (ey + 12'sd4 > 12'sd208) ? 12'sd208 : ey + 12'sd4;
            n_checks++; if (dut.r_top_y !== ey) begin n_fail++; $display("FAIL slide_step%0d got %0d exp %0d", p, $signed(dut.r_top_y), ey); end
        end
        n_checks++; if (dut.r_state !== ST_SLIDE) begin n_fail++; $display("FAIL slide_pre_hold got %0d exp %0d", dut.r_state, ST_SLIDE); end
        tick();
        n_checks++; if (dut.r_state !== ST_HOLD) begin n_fail++; $display("FAIL slide_to_hold got %0d exp %0d", dut.r_state, ST_HOLD); end
        frame();
        n_checks++; if (dut.r_top_y !== 12'sd208) begin n_fail++; $display("FAIL slide_overshoot got %0d exp 208", $signed(dut.r_top_y)); end
    endtask
    task automatic test_reset_mid_slide();
        restart();
        repeat (41) frame();
        n_checks++; if (dut.r_top_y !== 12'sd100) begin n_fail++; $display("FAIL mid_topy got %0d exp 100", $signed(dut.r_top_y)); end
        pixelX = 11'd300; pixelY = 11'd120;
        tick();
        n_checks++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd44, 11'd20}) begin n_fail++; $display("FAIL mid_inside got %b/%0d/%0d exp 1/44/20", InsideRectangle, offsetX, offsetY); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (dut.r_state !== ST_IDLE || dut.r_top_y !== -12'sd64) begin n_fail++; $display("FAIL mid_reset_state got %0d/%0d exp 0/-64", dut.r_state, $signed(dut.r_top_y)); end
        n_checks++; if ({InsideRectangle, bannerActive, offsetX, offsetY} !== 24'd0) begin n_fail++; $display("FAIL mid_reset_outputs got %h exp 0", {InsideRectangle, bannerActive, offsetX, offsetY}); end
    endtask
    task automatic test_scan();
        int xs[4] = '{255, 256, 383, 384};
        logic       ein;
        restart();
        repeat (8) frame();
        n_checks++; if (dut.r_top_y !== -12'sd32) begin n_fail++; $display("FAIL scan_topy got %0d exp -32", $signed(dut.r_top_y)); end
        pixelX = 11'd300;
        for (int y = 0; y <= 40; y++) begin
            pixelY = 11'(y);
            tick();
            ein = y <= 31;
            n_checks++; if (InsideRectangle !== ein) begin n_fail++; $display("FAIL scan_in_y%0d got %b exp %b", y, InsideRectangle, ein); end
            n_checks++; if (offsetY !== (ein ? 11'(y + 32) : 11'd0) || offsetX !== (ein ? 11'd44 : 11'd0)) begin n_fail++; $display("FAIL scan_off_y%0d got %0d/%0d exp %0d/%0d", y, offsetX, offsetY, ein ? 44 : 0, ein ? y + 32 : 0); end
        end
        pixelY = 11'd10;
        for (int i = 0; i < 4; i++) begin
            pixelX = 11'(xs[i]);
            tick();
            ein = (i == 1) || (i == 2);
            n_checks++; if ({InsideRectangle, offsetX, offsetY} !== {ein, ein ? 11'(xs[i] - 256) : 11'd0, ein ? 11'd42 : 11'd0}) begin n_fail++; $display("FAIL scan_x%0d got %b/%0d/%0d exp %b", xs[i], InsideRectangle, offsetX, offsetY, ein); end
        end
    endtask
    task automatic test_hold();
        logic ev;
        repeat (60) frame();
        n_checks++; if (dut.r_top_y !== 12'sd208) begin n_fail++; $display("FAIL hold_topy got %0d exp 208", $signed(dut.r_top_y)); end
        tick();
        n_checks++; if (dut.r_state !== ST_HOLD) begin n_fail++; $display("FAIL hold_enter got %0d exp %0d", dut.r_state, ST_HOLD); end
        pixelX = 11'd300; pixelY = 11'd210;
        for (int k = 0; k < 120; k++) begin
            tick();
            ev = BLINK ? (((k / 15) % 2) == 0) : 1'b1;
            n_checks++; if (InsideRectangle !== ev || offsetY !== (ev ? 11'd2 : 11'd0)) begin n_fail++; $display("FAIL hold_frame%0d got %b/%0d exp %b", k, InsideRectangle, offsetY, ev); end
            frame();
        end
        n_checks++; if (dut.r_state !== ST_HOLD) begin n_fail++; $display("FAIL hold_last got %0d exp %0d", dut.r_state, ST_HOLD); end
        tick();
        n_checks++; if (dut.r_state !== ST_DONE) begin n_fail++; $display("FAIL hold_to_done got %0d exp %0d", dut.r_state, ST_DONE); end
        for (int k = 0; k < 40; k++) begin
            frame();
            n_checks++; if (InsideRectangle !== 1'b1 || dut.r_top_y !== 12'sd208) begin n_fail++; $display("FAIL done_vis%0d got %b/%0d exp 1/208", k, InsideRectangle, $signed(dut.r_top_y)); end
        end
    endtask
    task automatic test_drop_done();
        gameWon = 1'b0;
        tick();
        n_checks++; if (bannerActive !== 1'b0 || dut.r_top_y !== -12'sd64) begin n_fail++; $display("FAIL drop_done got %b/%0d exp 0/-64", bannerActive, $signed(dut.r_top_y)); end
        tick();
        n_checks++; if (InsideRectangle !== 1'b0) begin n_fail++; $display("FAIL drop_idle_hidden got %b exp 0", InsideRectangle); end
        gameWon = 1'b1;
        tick();
        n_checks++; if (bannerActive !== 1'b1 || dut.r_top_y !== -12'sd64) begin n_fail++; $display("FAIL rewin_done got %b/%0d exp 1/-64", bannerActive, $signed(dut.r_top_y)); end
        frame();
        n_checks++; if (dut.r_top_y !== -12'sd60) begin n_fail++; $display("FAIL rewin_step got %0d exp -60", $signed(dut.r_top_y)); end
    endtask
    task automatic test_drop_hold();
        repeat (67) frame();
        tick();
        n_checks++; if (dut.r_state !== ST_HOLD) begin n_fail++; $display("FAIL drop_hold_enter got %0d exp %0d", dut.r_state, ST_HOLD); end
        gameWon = 1'b0;
        tick();
        n_checks++; if (bannerActive !== 1'b0 || dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL drop_hold got %b/%0d exp 0/0", bannerActive, dut.r_state); end
        gameWon = 1'b1;
        tick();
        n_checks++; if (dut.r_state !== ST_SLIDE || dut.r_top_y !== -12'sd64) begin n_fail++; $display("FAIL rewin_hold got %0d/%0d exp 1/-64", dut.r_state, $signed(dut.r_top_y)); end
    endtask
    initial begin
        test_reset();
        test_slide();
        test_reset_mid_slide();
        test_scan();
        test_hold();
        test_drop_done();
        test_drop_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/win_banner_square.md
WIN_BANNER_SQUARE -- requirements
Module: win_banner_square

Interface
REQ-001 Parameter TOP_LEFT_X, default 256, banner left edge in screen pixels.
REQ-002 Parameter TARGET_Y, default 208, final banner top edge.
REQ-003 Parameter SPEED, default 4, pixels moved down per frame while sliding.
REQ-004 Parameter HOLD_FRAMES, default 120, frames spent in HOLD.
REQ-005 Parameter BLINK_FRAMES, default 15, frames per blink half-period.
REQ-006 clk  in  1  system clock; all logic is on its rising edge.
REQ-007 reset  in  1  synchronous reset, active-high.
REQ-008 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-009 gameWon  in  1  level; high while the win condition holds.
REQ-010 pixelX  in  11  current scan pixel column.
REQ-011 pixelY  in  11  current scan pixel row.
REQ-012 offsetX  out  11  pixelX minus banner left edge, feeds the win bitmap.
REQ-013 offsetY  out  11  pixelY minus banner top edge, feeds the win bitmap.
REQ-014 InsideRectangle  out  1  pixel lies inside the visible 128x64 banner.
REQ-015 bannerActive  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SLIDE, HOLD, DONE.
REQ-017 IDLE->SLIDE on gameWon=1, with topY loaded to -64 (12-bit signed).
REQ-018 In SLIDE, on each startOfFrame, topY SHALL become min(topY+SPEED, TARGET_Y); a frame pulse in the entry cycle is ignored.
REQ-019 SLIDE->HOLD on the cycle topY equals TARGET_Y, with the frame counter cleared.
REQ-020 In HOLD the frame counter SHALL increment per startOfFrame; HOLD->DONE when it reaches HOLD_FRAMES.
REQ-021 DONE SHALL hold topY=TARGET_Y, banner always visible.
REQ-022 gameWon=0 in any non-IDLE state SHALL force IDLE on the next edge and reset topY to -64.
REQ-023 Containment: TOP_LEFT_X<=pixelX<TOP_LEFT_X+128 and topY<=pixelY<topY+64, signed 12-bit compares; rows with negative screen Y never match.
REQ-024 offsetX/offsetY SHALL be the low 11 bits of the differences; they are meaningful only when InsideRectangle=1 and are 0 otherwise.
REQ-025 InsideRectangle SHALL be 0 in IDLE and when the blink phase is off.
REQ-026 Outputs SHALL be registered: one clk latency from pixelX/pixelY to offsets and InsideRectangle.

Reset
REQ-027 reset SHALL set state=IDLE, topY=-64, counters=0, blink phase on, and all outputs to 0; it takes priority over every other input.

Configuration
REQ-028 With WIN_BANNER_BLINK_EN defined, in HOLD the blink phase SHALL toggle every BLINK_FRAMES frames, starting on, and the banner is hidden while the phase is off.
REQ-029 Without WIN_BANNER_BLINK_EN, the blink phase SHALL be constant on and no blink counter is synthesized.
REQ-030 In SLIDE and DONE the banner SHALL always be visible, regardless of the macro.

Structure
REQ-031 Banner width (128), height (64), the initial topY (-64), the screen size (640x480) and the FSM state enum SHALL live in the shared game package.
REQ-032 One sub-module, frame_tick_counter, SHALL be used: it counts startOfFrame pulses with a clear input, and is instantiated twice, once for HOLD and once for blink.

Verification
REQ-033 Apply reset mid-SLIDE with topY=100 -> next cycle state=IDLE, topY=-64, and all outputs 0.
REQ-034 Raise gameWon, then give 68 frame pulses with defaults -> topY sequence -60, -56, ..., reaching 208 exactly on pulse 68; HOLD is entered and there is no overshoot.
REQ-035 Set topY=-32 in SLIDE and scan pixelY=0..40 at pixelX=300 -> InsideRectangle=1 for rows 0..31 only, with offsetY=32..63 and offsetX=44, each one cycle late.
REQ-036 With WIN_BANNER_BLINK_EN defined, run through HOLD -> InsideRectangle is on for frames 0-14, off for 15-29, and so on; DONE follows after frame 120 and stays visible permanently.
REQ-037 Drop gameWon in HOLD and in DONE -> IDLE next cycle with bannerActive=0; raise it again -> a fresh slide starts from -64.
